// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl
//   Load/store unit front end. Accepts one load or store from the execute
//   stage, stalls the pipeline while a single data-memory request is in
//   flight, and returns an extended load result.
//
//   Parameter
//     TIMEOUT      max REQ cycles without mem_ready before a fault (2..255)
//
//   Ports
//     clk, rst     clock, synchronous active-high reset
//     ex_valid     execute-stage instruction valid
//     ex_load      load in execute
//     ex_store     store in execute
//     ex_fun3      funct3 of the execute-stage instruction
//     ex_addr      byte address from the ALU
//     ex_wdata     store data (rs2)
//     stall        freeze upstream pipeline registers
//     mem_req      data-memory request valid
//     mem_we       1 = write, 0 = read
//     mem_addr     word-aligned address
//     mem_be       byte enables (zero for loads)
//     mem_wdata    lane-replicated write data (zero for loads)
//     mem_ready    memory completes the request this cycle
//     mem_rdata    read word, valid with mem_ready
//     ld_data      extended load result, held until the next load completes
//     ld_valid     one-cycle pulse qualifying ld_data
//     access_fault one-cycle pulse: bad funct3, misaligned, load&store, timeout
// ---------------------------------------------------------------------------
module mem_access_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        ex_load,
    input  logic        ex_store,
    input  logic [2:0]  ex_fun3,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [31:0] ld_data,
    output logic        ld_valid,
    output logic        access_fault
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t      state;
    logic [7:0]  wait_cnt;
    logic [2:0]  fun3_q;
    logic [1:0]  off_q;      // byte offset, needed to pick the load lane

    logic        access, both, legal, misalign, accept, bad;
    logic [3:0]  be_nxt;
    logic [31:0] wdata_nxt;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    // ---------------- execute-stage decode ----------------
    always_comb begin
        access = ex_valid & (ex_load ^ ex_store);
        both   = ex_valid & ex_load & ex_store;

        legal = 1'b0;
        if (ex_load) begin
            case (ex_fun3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
                default:                                 legal = 1'b0;
            endcase
        end else begin
            case (ex_fun3)
                3'b000, 3'b001, 3'b010: legal = 1'b1;
                default:                legal = 1'b0;
            endcase
        end

        // fun3[1:0] encodes the access size for every legal value
        case (ex_fun3[1:0])
            2'b01:   misalign = ex_addr[0];
            2'b10:   misalign = (ex_addr[1:0] != 2'b00);
            default: misalign = 1'b0;
        endcase

        accept = (state == IDLE) & access & legal & ~misalign;
        bad    = (state == IDLE) & (both | (access & (~legal | misalign)));

        // Write-side lanes only matter for stores; loads leave them at zero.
        be_nxt    = 4'b0000;
        wdata_nxt = 32'h0;
        if (ex_store) begin
            case (ex_fun3[1:0])
                2'b00: begin
                    be_nxt    = 4'b0001 << ex_addr[1:0];
                    wdata_nxt = {4{ex_wdata[7:0]}};
                end
                2'b01: begin
                    be_nxt    = 4'b0011 << {ex_addr[1], 1'b0};
                    wdata_nxt = {2{ex_wdata[15:0]}};
                end
                default: begin
                    be_nxt    = 4'b1111;
                    wdata_nxt = ex_wdata;
                end
            endcase
        end
    end

    // Stall rises combinationally on the accept cycle so the instruction
    // behind the access is frozen before the REQ state is even entered.
    assign stall = accept | (state == REQ);

    // ---------------- load extraction ----------------
    always_comb begin
        case (off_q)
            2'b00:   ld_byte = mem_rdata[7:0];
            2'b01:   ld_byte = mem_rdata[15:8];
            2'b10:   ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
        ld_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (fun3_q)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {24'h0, ld_byte};
            3'b101:  ld_ext = {16'h0, ld_half};
            default: ld_ext = mem_rdata;
        endcase
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            wait_cnt     <= 8'd0;
            fun3_q       <= 3'b000;
            off_q        <= 2'b00;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= 32'h0;
            mem_be       <= 4'b0000;
            mem_wdata    <= 32'h0;
            ld_data      <= 32'h0;
            ld_valid     <= 1'b0;
            access_fault <= 1'b0;
        end else begin
            ld_valid     <= 1'b0;
            access_fault <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state     <= REQ;
                        wait_cnt  <= 8'd0;
                        fun3_q    <= ex_fun3;
                        off_q     <= ex_addr[1:0];
                        mem_req   <= 1'b1;
                        mem_we    <= ex_store;
                        mem_addr  <= {ex_addr[31:2], 2'b00};
                        mem_be    <= be_nxt;
                        mem_wdata <= wdata_nxt;
                    end else if (bad) begin
                        access_fault <= 1'b1;
                    end
                end
                REQ: begin
                    if (mem_ready) begin
                        state   <= DONE;
                        mem_req <= 1'b0;
                        if (!mem_we) begin
                            ld_data  <= ld_ext;
                            ld_valid <= 1'b1;
                        end
                    end else if (wait_cnt == 8'(TIMEOUT - 1)) begin
                        state        <= DONE;
                        mem_req      <= 1'b0;
                        access_fault <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                DONE: begin
                    // ex_* are ignored here: the stalled instruction is
                    // only now being released.
                    state <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_load, ex_store;
    logic [2:0]  ex_fun3;
    logic [31:0] ex_addr, ex_wdata;
    logic        stall, mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [31:0] ld_data;
    logic        ld_valid, access_fault;

    mem_access_ctrl #(.TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_load(ex_load), .ex_store(ex_store),
        .ex_fun3(ex_fun3), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
        .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .ld_data(ld_data), .ld_valid(ld_valid), .access_fault(access_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          nreq;
    } mem_item_t;

    typedef struct {
        logic        fault;
        logic [31:0] data;
    } ev_t;

    mem_item_t mem_q[$];
    ev_t       ev_q[$];

    int checks = 0;
    int errors = 0;
    int wait_cfg = 0;
    logic idle_ready = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic void push_mem(input logic [31:0] a, input logic we,
                                     input logic [3:0] be, input logic [31:0] wd,
                                     input int n);
        mem_item_t it;
        it.addr = a; it.we = we; it.be = be; it.wdata = wd; it.nreq = n;
        mem_q.push_back(it);
    endfunction

    function automatic void push_ev(input logic f, input logic [31:0] d);
        ev_t e;
        e.fault = f; e.data = d;
        ev_q.push_back(e);
    endfunction

    // Memory responder: ready after wait_cfg REQ cycles; idle_ready lets the
    // bench drive mem_ready while no request is outstanding.
    initial begin
        int seen = 0;
        mem_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_req === 1'b1) begin
                mem_ready = (seen >= wait_cfg);
                seen++;
            end else begin
                seen = 0;
                mem_ready = idle_ready;
            end
        end
    end

    // Monitor: checks every request cycle against the head of mem_q, the
    // request length when mem_req falls, and every ld_valid/fault pulse.
    initial begin
        logic prev_req = 1'b0;
        int   req_cycles = 0;
        forever begin
            @(negedge clk);
            if (mem_req === 1'b1) begin
                if (mem_q.size() == 0) begin
                    chk("unexpected_mem_req", 32'd1, 32'd0);
                end else begin
                    chk("req_addr",  mem_addr,  mem_q[0].addr);
                    chk("req_we",    {31'h0, mem_we}, {31'h0, mem_q[0].we});
                    chk("req_be",    {28'h0, mem_be}, {28'h0, mem_q[0].be});
                    chk("req_wdata", mem_wdata, mem_q[0].wdata);
                end
                req_cycles++;
            end else if (prev_req) begin
                if (mem_q.size() != 0) begin
                    mem_item_t it;
                    it = mem_q.pop_front();
                    chk("req_cycles", req_cycles, it.nreq);
                end
                req_cycles = 0;
            end
            prev_req = (mem_req === 1'b1);

            if (ld_valid === 1'b1) begin
                if (ev_q.size() == 0) chk("unexpected_ld_valid", 32'd1, 32'd0);
                else begin
                    ev_t e;
                    e = ev_q.pop_front();
                    chk("ev_kind_ld", 32'd0, {31'h0, e.fault});
                    chk("ld_data", ld_data, e.data);
                end
            end
            if (access_fault === 1'b1) begin
                if (ev_q.size() == 0) chk("unexpected_fault", 32'd1, 32'd0);
                else begin
                    ev_t e;
                    e = ev_q.pop_front();
                    chk("ev_kind_fault", 32'd1, {31'h0, e.fault});
                end
            end
        end
    end

    // One access from execute; counts stall cycles (bounded) and compares.
    task automatic access(input string nm, input logic ld, input logic st,
                          input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rd,
                          input int waits, input int exp_stall);
        int n = 0;
        wait_cfg  = waits;
        mem_rdata = rd;
        @(posedge clk); #1;
        ex_valid = 1'b1; ex_load = ld; ex_store = st;
        ex_fun3 = f3; ex_addr = a; ex_wdata = wd;
        @(negedge clk);
        if (stall === 1'b1) n++;
        @(posedge clk); #1;
        ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (stall === 1'b1) n++;
            else break;
        end
        chk({nm, "_stall"}, n, exp_stall);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0;
        ex_fun3 = 3'b000; ex_addr = 32'h0; ex_wdata = 32'h0;
        mem_rdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_stall",   {31'h0, stall},        32'd0);
        chk("rst_mem_req", {31'h0, mem_req},      32'd0);
        chk("rst_mem_we",  {31'h0, mem_we},       32'd0);
        chk("rst_ldv",     {31'h0, ld_valid},     32'd0);
        chk("rst_fault",   {31'h0, access_fault}, 32'd0);
        chk("rst_addr",    mem_addr,              32'h0);
        chk("rst_be",      {28'h0, mem_be},       32'h0);
        chk("rst_wdata",   mem_wdata,             32'h0);
        chk("rst_ld_data", ld_data,               32'h0);
        @(posedge clk); #1 rst = 1'b0;

        // lb at offset 3, ready on first REQ cycle
        push_mem(32'h1000, 1'b0, 4'b0000, 32'h0, 1); push_ev(1'b0, 32'hFFFF_FF80);
        access("lb", 1, 0, 3'b000, 32'h1003, 32'h1111_1111, 32'h80FF_1234, 0, 2);

        // sh upper half, 3 wait cycles
        push_mem(32'h2000, 1'b1, 4'b1100, 32'hABCD_ABCD, 4);
        access("sh", 0, 1, 3'b001, 32'h2002, 32'h0000_ABCD, 32'h0, 3, 5);
        chk("ld_hold_store", ld_data, 32'hFFFF_FF80);

        // misaligned lw
        push_ev(1'b1, 32'h0);
        access("lw_mis", 1, 0, 3'b010, 32'h3001, 32'h0, 32'h0, 0, 0);
        chk("ld_hold_fault", ld_data, 32'hFFFF_FF80);

        // lhu with memory never ready -> timeout
        push_mem(32'h4000, 1'b0, 4'b0000, 32'h0, 16); push_ev(1'b1, 32'h0);
        access("lhu_to", 1, 0, 3'b101, 32'h4000, 32'h0, 32'h0, 1000, 17);

        // stores: sb lane 2, sw with waits
        push_mem(32'h6000, 1'b1, 4'b0100, 32'h7878_7878, 1);
        access("sb", 0, 1, 3'b000, 32'h6002, 32'h1234_5678, 32'h0, 0, 2);
        push_mem(32'h7000, 1'b1, 4'b1111, 32'hDEAD_BEEF, 3);
        access("sw", 0, 1, 3'b010, 32'h7000, 32'hDEAD_BEEF, 32'h0, 2, 4);

        // load extension variants
        push_mem(32'h8000, 1'b0, 4'b0000, 32'h0, 1); push_ev(1'b0, 32'hFFFF_8001);
        access("lh", 1, 0, 3'b001, 32'h8002, 32'h0, 32'h8001_7FFF, 0, 2);
        push_mem(32'h8000, 1'b0, 4'b0000, 32'h0, 1); push_ev(1'b0, 32'h0000_7FFF);
        access("lhu", 1, 0, 3'b101, 32'h8000, 32'h0, 32'h8001_7FFF, 0, 2);
        push_mem(32'hA000, 1'b0, 4'b0000, 32'h0, 1); push_ev(1'b0, 32'h0000_007F);
        access("lb_pos", 1, 0, 3'b000, 32'hA000, 32'h0, 32'h0000_007F, 0, 2);
        push_mem(32'hA000, 1'b0, 4'b0000, 32'h0, 1); push_ev(1'b0, 32'h0000_0080);
        access("lbu", 1, 0, 3'b100, 32'hA003, 32'h0, 32'h8000_0000, 0, 2);

        // mem_ready high while idle must be ignored
        idle_ready = 1'b1;
        repeat (3) @(posedge clk);
        push_mem(32'h9000, 1'b0, 4'b0000, 32'h0, 2); push_ev(1'b0, 32'hCAFE_BABE);
        access("lw_idle_rdy", 1, 0, 3'b010, 32'h9000, 32'h0, 32'hCAFE_BABE, 1, 3);
        idle_ready = 1'b0;

        // illegal encodings / conflicts
        push_ev(1'b1, 32'h0);
        access("lwu", 1, 0, 3'b110, 32'h0, 32'h0, 32'h0, 0, 0);
        push_ev(1'b1, 32'h0);
        access("st_f3_100", 0, 1, 3'b100, 32'h0, 32'h0, 32'h0, 0, 0);
        push_ev(1'b1, 32'h0);
        access("ld_and_st", 1, 1, 3'b010, 32'h0, 32'h0, 32'h0, 0, 0);
        push_ev(1'b1, 32'h0);
        access("sh_mis", 0, 1, 3'b001, 32'h0001, 32'h0, 32'h0, 0, 0);
        access("no_op", 0, 0, 3'b010, 32'h0, 32'h0, 32'h0, 0, 0);

        // reset during the 2nd REQ cycle of a lw
        push_mem(32'h3000, 1'b0, 4'b0000, 32'h0, 2);
        wait_cfg = 1000;
        @(posedge clk); #1;
        ex_valid = 1'b1; ex_load = 1'b1; ex_store = 1'b0;
        ex_fun3 = 3'b010; ex_addr = 32'h3000;
        @(posedge clk); #1;
        ex_valid = 1'b0; ex_load = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_mem_req", {31'h0, mem_req},      32'd0);
        chk("abort_stall",   {31'h0, stall},        32'd0);
        chk("abort_ldv",     {31'h0, ld_valid},     32'd0);
        chk("abort_fault",   {31'h0, access_fault}, 32'd0);
        push_mem(32'h5000, 1'b0, 4'b0000, 32'h0, 1); push_ev(1'b0, 32'h0000_0099);
        access("lbu_after_rst", 1, 0, 3'b100, 32'h5001, 32'h0, 32'h0000_9900, 0, 2);

        repeat (4) @(negedge clk);
        chk("mem_q_empty", mem_q.size(), 32'd0);
        chk("ev_q_empty",  ev_q.size(),  32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
